// File: rtl/mod_const_fetch.sv
// mod_const_fetch: bursts 32-bit constants out of four byte-lane EEPROMs.
// Ports: clk/rst, start/sel, EEPROM a/ce_n/oe_n/we_n/d1..d4, word/idx/valid/ready/last, busy/done.
module mod_const_fetch #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sel,
  output logic [12:0] a,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  input  logic [7:0]  d3,
  input  logic [7:0]  d4,
  output logic [31:0] word,
  output logic [5:0]  idx,
  output logic        valid,
  input  logic        ready,
  output logic        last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    PRESENT
  } state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] wcnt;
  logic       sel_q;
  logic       start_q;
  logic [5:0] fin;

  assign fin = sel_q ? 6'd63 : 6'd7;

  // start/sel pass through one input register while idle, so the
  // first word lands WAIT_CYCLES+2 edges after start is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      a       <= '0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      word    <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      we_n <= 1'b1;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          start_q <= start & ~start_q;
          if (start & ~start_q)
            sel_q <= sel;
          if (start_q) begin
            state <= ADDR;
            idx   <= '0;
            a     <= sel_q ? 13'd8 : 13'd0;
            ce_n  <= 1'b0;
            oe_n  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (wcnt == WLAST) begin
            word  <= {d1, d2, d3, d4};
            valid <= 1'b1;
            last  <= (idx == fin);
            ce_n  <= 1'b1;
            oe_n  <= 1'b1;
            state <= PRESENT;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        PRESENT: begin
          if (ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (idx == fin) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + 6'd1;
              a     <= a + 13'd1;
              ce_n  <= 1'b0;
              oe_n  <= 1'b0;
              state <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_const_fetch.sv
// tb_mod_const_fetch: scoreboard bench for mod_const_fetch.
// Drives H/K bursts, stalls, ignored starts, reset abort, WAIT_CYCLES=5.
module tb_mod_const_fetch;

  localparam logic [31:0] ROMV [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] word;
    logic        last;
    logic [12:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, sel = 1'b0, ready = 1'b0;
  logic [12:0] a;
  logic        ce_n, oe_n, we_n, valid, last, busy, done;
  logic [31:0] word, dw;
  logic [5:0]  idx;

  logic        start5 = 1'b0, sel5 = 1'b0, ready5 = 1'b1;
  logic [12:0] a5;
  logic        ce5_n, oe5_n, we5_n, valid5, last5, busy5, done5;
  logic [31:0] word5, dw5;
  logic [5:0]  idx5;

  assign dw = (!ce_n && !oe_n && a < 13'd72) ?
              ROMV[a[6:0]] : 32'hdeadbeef;
  assign dw5 = (!ce5_n && !oe5_n && a5 < 13'd72) ?
               ROMV[a5[6:0]] : 32'hdeadbeef;

  mod_const_fetch #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .a(a), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .d1(dw[31:24]), .d2(dw[23:16]), .d3(dw[15:8]), .d4(dw[7:0]),
    .word(word), .idx(idx), .valid(valid), .ready(ready),
    .last(last), .busy(busy), .done(done)
  );

  mod_const_fetch #(.WAIT_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .start(start5), .sel(sel5),
    .a(a5), .ce_n(ce5_n), .oe_n(oe5_n), .we_n(we5_n),
    .d1(dw5[31:24]), .d2(dw5[23:16]), .d3(dw5[15:8]), .d4(dw5[7:0]),
    .word(word5), .idx(idx5), .valid(valid5), .ready(ready5),
    .last(last5), .busy(busy5), .done(done5)
  );

  int vectors = 0;
  int errors = 0;
  int got = 0;
  int cyc = 0;
  int lastcyc = 0;
  logic [31:0] firstword, lastword;
  logic        lastflag;
  exp_t        sbq[$];
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && ready) begin
      vectors++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra idx=%0d word=%h required=none",
                 idx, word);
      end else begin
        e = sbq.pop_front();
        if ({idx, word, last, a, ce_n, oe_n, we_n} !==
            {e.idx, e.word, e.last, e.a, 3'b111}) begin
          errors++;
          $display("FAIL sb_word got idx=%0d word=%h last=%b a=%0d ctl=%b%b%b required idx=%0d word=%h last=%b a=%0d ctl=111",
                   idx, word, last, a, ce_n, oe_n, we_n,
                   e.idx, e.word, e.last, e.a);
        end
      end
      if (got == 0) firstword = word;
      lastword = word;
      lastflag = last;
      lastcyc = cyc;
      got++;
    end
  end

  function automatic void push_burst(input logic s);
    int n, base;
    exp_t x;
    n = s ? 64 : 8;
    base = s ? 8 : 0;
    for (int i = 0; i < n; i++) begin
      x.idx = 6'(i);
      x.word = ROMV[base + i];
      x.last = (i == n - 1);
      x.a = 13'(base + i);
      sbq.push_back(x);
    end
  endfunction

  task automatic pulse_start(input logic s);
    @(posedge clk);
    #1 start = 1'b1;
    sel = s;
    @(posedge clk);
    #1 start = 1'b0;
    sel = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a, ce_n, oe_n, we_n, word, idx, valid, last, busy, done} !==
        {13'd0, 3'b111, 32'd0, 6'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_w2 got a=%0d ctl=%b%b%b word=%h idx=%0d v=%b l=%b b=%b d=%b required all reset values",
               a, ce_n, oe_n, we_n, word, idx, valid, last, busy, done);
    end
    vectors++;
    if ({a5, ce5_n, oe5_n, we5_n, word5, idx5,
         valid5, last5, busy5, done5} !==
        {13'd0, 3'b111, 32'd0, 6'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_w5 got a=%0d word=%h v=%b b=%b required reset values",
               a5, word5, valid5, busy5);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_h_burst();
    bit seen, early;
    int c0;
    got = 0;
    push_burst(1'b0);
    ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid) early = 1'b1;
    end
    vectors++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL h_latency_early got valid before edge 4 required none");
    end
    @(negedge clk);
    c0 = cyc;
    vectors++;
    if ({valid, idx, word} !== {1'b1, 6'd0, 32'h6a09e667}) begin
      errors++;
      $display("FAIL h_first got v=%b idx=%0d word=%h required v=1 idx=0 word=6a09e667",
               valid, idx, word);
    end
    wait_done(60, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL h_done_timeout got no done required done");
    end
    vectors++;
    if ({busy, valid, last} !== 3'b000) begin
      errors++;
      $display("FAIL h_done_state got b=%b v=%b l=%b required 000",
               busy, valid, last);
    end
    @(negedge clk);
    vectors++;
    if ({got, lastword, lastflag, done} !==
        {32'd8, 32'h5be0cd19, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL h_summary got n=%0d last=%h lf=%b done=%b required n=8 last=5be0cd19 lf=1 done=0",
               got, lastword, lastflag, done);
    end
    vectors++;
    if (lastcyc - c0 !== 28) begin
      errors++;
      $display("FAIL h_period got %0d cycles required 28",
               lastcyc - c0);
    end
  endtask

  task automatic test_k_burst();
    bit seen;
    got = 0;
    push_burst(1'b1);
    ready = 1'b1;
    pulse_start(1'b1);
    wait_done(400, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL k_done_timeout got no done required done");
    end
    @(negedge clk);
    vectors++;
    if ({got, firstword, lastword, lastflag} !==
        {32'd64, 32'h428a2f98, 32'hc67178f2, 1'b1}) begin
      errors++;
      $display("FAIL k_summary got n=%0d first=%h last=%h lf=%b required n=64 first=428a2f98 last=c67178f2 lf=1",
               got, firstword, lastword, lastflag);
    end
  endtask

  task automatic test_stall();
    bit seen, hit;
    got = 0;
    push_burst(1'b0);
    ready = 1'b1;
    pulse_start(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (valid && idx == 6'd2) hit = 1'b1;
    end
    @(posedge clk);
    #1 ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (valid) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL stall_reach got no word 3 required word 3");
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if ({valid, idx, word, a, ce_n, oe_n, last} !==
          {1'b1, 6'd3, 32'ha54ff53a, 13'd3, 3'b110}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d word=%h a=%0d ce=%b oe=%b required v=1 idx=3 word=a54ff53a a=3 ce=1 oe=1",
                 i, valid, idx, word, a, ce_n, oe_n);
      end
    end
    ready = 1'b1;
    wait_done(60, seen);
    @(negedge clk);
    vectors++;
    if ({seen, got, lastword} !== {1'b1, 32'd8, 32'h5be0cd19}) begin
      errors++;
      $display("FAIL stall_resume got done=%b n=%0d last=%h required done=1 n=8 last=5be0cd19",
               seen, got, lastword);
    end
  endtask

  task automatic test_start_ignored();
    bit seen, stray;
    got = 0;
    push_burst(1'b0);
    ready = 1'b1;
    pulse_start(1'b0);
    repeat (6) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_busy got %b required 1", busy);
    end
    pulse_start(1'b1);
    wait_done(60, seen);
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid || busy) stray = 1'b1;
    end
    vectors++;
    if ({seen, stray, got, firstword, lastword} !==
        {1'b1, 1'b0, 32'd8, 32'h6a09e667, 32'h5be0cd19}) begin
      errors++;
      $display("FAIL ign_burst got done=%b stray=%b n=%0d first=%h last=%h required 1 0 8 6a09e667 5be0cd19",
               seen, stray, got, firstword, lastword);
    end
  endtask

  task automatic test_reset_abort();
    bit seen, hit;
    got = 0;
    push_burst(1'b1);
    ready = 1'b1;
    pulse_start(1'b1);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (valid && idx == 6'd40) hit = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({hit, a, ce_n, oe_n, we_n, word, idx,
         valid, last, busy, done} !==
        {1'b1, 13'd0, 3'b111, 32'd0, 6'd0, 4'b0000}) begin
      errors++;
      $display("FAIL abort_reset got hit=%b a=%0d word=%h idx=%0d v=%b b=%b d=%b required hit=1 and reset values",
               hit, a, word, idx, valid, busy, done);
    end
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    got = 0;
    push_burst(1'b0);
    pulse_start(1'b0);
    wait_done(60, seen);
    @(negedge clk);
    vectors++;
    if ({seen, got, firstword} !== {1'b1, 32'd8, 32'h6a09e667}) begin
      errors++;
      $display("FAIL abort_restart got done=%b n=%0d first=%h required 1 8 6a09e667",
               seen, got, firstword);
    end
  endtask

  task automatic test_back_to_back();
    bit s1, s2;
    got = 0;
    push_burst(1'b0);
    push_burst(1'b0);
    ready = 1'b1;
    pulse_start(1'b0);
    wait_done(60, s1);
    start = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, s2);
    @(negedge clk);
    vectors++;
    if ({s1, s2, got} !== {2'b11, 32'd16}) begin
      errors++;
      $display("FAIL b2b got done1=%b done2=%b n=%0d required 1 1 16",
               s1, s2, got);
    end
  endtask

  task automatic test_wait5();
    bit seen, ctlbad;
    int run, nw, firstv;
    run = 0;
    nw = 0;
    firstv = -1;
    seen = 1'b0;
    ctlbad = 1'b0;
    @(posedge clk);
    #1 start5 = 1'b1;
    @(posedge clk);
    #1 start5 = 1'b0;
    for (int k = 0; k < 120 && !seen; k++) begin
      @(negedge clk);
      if (ce5_n !== oe5_n || we5_n !== 1'b1) ctlbad = 1'b1;
      if (!ce5_n) run++;
      if (valid5) begin
        if (firstv < 0) firstv = k;
        vectors++;
        if (run !== 6 || word5 !== ROMV[idx5]) begin
          errors++;
          $display("FAIL w5_word idx=%0d got low=%0d word=%h required low=6 word=%h",
                   idx5, run, word5, ROMV[idx5]);
        end
        run = 0;
        nw++;
      end
      if (done5) seen = 1'b1;
    end
    vectors++;
    if ({seen, ctlbad, firstv, nw} !== {2'b10, 32'd7, 32'd8}) begin
      errors++;
      $display("FAIL w5_summary got done=%b ctlbad=%b first_edge=%0d n=%0d required 1 0 7 8",
               seen, ctlbad, firstv, nw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_h_burst();
    test_k_burst();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_wait5();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
